// File: rtl/sseg_scan_mux.sv
// Scan controller for a common-anode multi-digit seven-segment display.
// It shadows its inputs once per frame and blanks all anodes at the start of each digit slot.
module sseg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     DigitEn,
  input  logic [DIGITS-1:0]     DpIn,
  output logic [3:0]            Num,
  output logic [DIGITS-1:0]     Anode,
  output logic                  Dp,
  output logic                  FrameStart
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_en;
  logic [DIGITS-1:0]   sh_dp;

  logic                blank;
  logic [IW-1:0]       sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt    <= '0;
      idx    <= '0;
      sh_val <= Value;
      sh_en  <= DigitEn;
      sh_dp  <= DpIn;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      if (idx == IDX_LAST) begin
        idx    <= '0;
        sh_val <= Value;
        sh_en  <= DigitEn;
        sh_dp  <= DpIn;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign blank = (cnt < BLANK_END);
  // While Reset is high, Num shows digit 0 and the display stays dark.
  assign sel   = Reset ? '0 : idx;

  // NOTE: every output gets a default before the loop, so no path can infer a latch.
  always_comb begin
    Num   = '0;
    Anode = '1;
    Dp    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == IW'(i)) begin
        Num = sh_val[4*i +: 4];
      end
      if (!Reset && !blank && idx == IW'(i) && sh_en[i]) begin
        Anode[i] = 1'b0;
        Dp       = ~sh_dp[i];
      end
    end
  end

  assign FrameStart = !Reset && (cnt == '0) && (idx == '0);

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1).
// Expected outputs come from a cycle-number timeline pushed to a scoreboard queue.
module tb_sseg_scan_mux;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Value;
  logic [3:0]  DigitEn;
  logic [3:0]  DpIn;
  logic [3:0]  Num;
  logic [3:0]  Anode;
  logic        Dp;
  logic        FrameStart;

  sseg_scan_mux #(
    .DIGITS       (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Value      (Value),
    .DigitEn    (DigitEn),
    .DpIn       (DpIn),
    .Num        (Num),
    .Anode      (Anode),
    .Dp         (Dp),
    .FrameStart (FrameStart)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] num;
    logic [3:0] anode;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n      = 0;

  logic [15:0] fv;
  logic [3:0]  fe;
  logic [3:0]  fd;

  logic        p_rst;
  logic [15:0] p_val;
  logic [3:0]  p_en;
  logic [3:0]  p_dp;

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 8'b11111100;  4'h1: seg = 8'b01100000;
      4'h2: seg = 8'b11011010;  4'h3: seg = 8'b11110010;
      4'h4: seg = 8'b01100110;  4'h5: seg = 8'b10110110;
      4'h6: seg = 8'b10111110;  4'h7: seg = 8'b11100000;
      4'h8: seg = 8'b11111110;  4'h9: seg = 8'b11110110;
      4'hA: seg = 8'b11101110;  4'hB: seg = 8'b00111110;
      4'hC: seg = 8'b10011100;  4'hD: seg = 8'b01111010;
      4'hE: seg = 8'b10011110;  default: seg = 8'b10001110;
    endcase
  endfunction

  // Cycle n of a frame: slot n/4, first cycle of each slot blank, frame of 16 cycles.
  function automatic exp_t timeline(input int c, input logic [15:0] v,
                                    input logic [3:0] e, input logic [3:0] d);
    exp_t       t;
    int         slot;
    logic [3:0] mask;
    slot    = (c / 4) % 4;
    mask    = 4'(1 << slot);
    t.num   = 4'(v >> (4 * slot));
    t.anode = ((c % 4) != 0 && (e & mask) != 4'b0) ? ~mask : 4'hF;
    t.dp    = (t.anode != 4'hF && (d & mask) != 4'b0) ? 1'b0 : 1'b1;
    t.fs    = ((c % 16) == 0);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, expv);
    end
  endtask

  // One clock: update the frame model at the edge, drive pending inputs, push expectation, compare.
  task automatic cyc();
    exp_t e;
    @(posedge Clk);
    if (Reset) begin
      n = 0; fv = Value; fe = DigitEn; fd = DpIn;
    end else begin
      if ((n % 16) == 15) begin
        fv = Value; fe = DigitEn; fd = DpIn;
      end
      n++;
    end
    #1;
    Reset   = p_rst;
    Value   = p_val;
    DigitEn = p_en;
    DpIn    = p_dp;
    if (Reset) e = '{num: fv[3:0], anode: 4'hF, dp: 1'b1, fs: 1'b0};
    else       e = timeline(n, fv, fe, fd);
    sb.push_back(e);
    @(negedge Clk);
    e = sb.pop_front();
    chk("num",        8'(Num),        8'(e.num));
    chk("anode",      8'(Anode),      8'(e.anode));
    chk("dp",         8'(Dp),         8'(e.dp));
    chk("framestart", 8'(FrameStart), 8'(e.fs));
  endtask

  initial begin
    Reset = 1'b1; Value = 16'h4321; DigitEn = 4'hF; DpIn = 4'h0;
    p_rst = 1'b1; p_val = 16'h4321; p_en  = 4'hF; p_dp = 4'h0;
    fv = 16'h0; fe = 4'h0; fd = 4'h0;

    repeat (3) cyc();

    p_rst = 1'b0;
    for (int c = 0; c < 91; c++) begin
      if (c == 6)  p_val = 16'hABCD;
      if (c == 20) begin p_val = 16'h4321; p_en = 4'b0101; end
      if (c == 36) begin p_en = 4'hF; p_dp = 4'b0010; end
      if (c == 73) begin p_rst = 1'b1; p_dp = 4'h0; end
      if (c == 74) p_rst = 1'b0;
      cyc();
      if (c == 13) chk("cathode", seg(Num), 8'b01100110);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
